sub_sequencer: RTL

Operand sequencer and result/flag register wrapped around the 6-bit `sub` unit in the ALU. It captures two operands one at a time from a shared 6-bit input on successive LOAD presses and drives them onto the subtractor's A/B inputs. It then registers SUB_RESULT together with overflow, zero and negative flags, and holds them for display. The subtractor stays purely combinational; this block supplies all of the sequencing.

---
 rtl/sub_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/sub_sequencer.sv
// Operand sequencer and result/flag register around the combinational 6-bit subtractor.
// Captures A then B on LOAD rising edges, registers the difference and flags, then holds them for display.
module sub_sequencer #(
  parameter int WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             LOAD,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] SUB_RESULT,
  output logic [WIDTH-1:0] RESULT,
  output logic             OVF,
  output logic             ZERO,
  output logic             NEG,
  output logic             DONE,
  output logic [1:0]       STATE
);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    EXEC   = 2'b10,
    SHOW   = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_load_q;
  logic             w_ld;
  logic             w_ld_a;
  logic             w_ld_b;
  logic             w_exec;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;

  // load_q resets high so a LOAD held through reset release is not a press
  assign w_ld = LOAD & ~r_load_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_load_q <= 1'b1;
    end else begin
      r_load_q <= LOAD;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= WAIT_A;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_A:  if (w_ld) w_next = WAIT_B;
      WAIT_B:  if (w_ld) w_next = EXEC;
      EXEC:    w_next = SHOW;
      SHOW:    if (w_ld) w_next = WAIT_B;
      default: w_next = WAIT_A;
    endcase
  end

  always_comb begin
    w_ld_a = 1'b0;
    w_ld_b = 1'b0;
    w_exec = 1'b0;
    case (r_state)
      WAIT_A:  w_ld_a = w_ld;
      WAIT_B:  w_ld_b = w_ld;
      EXEC:    w_exec = 1'b1;
      SHOW:    w_ld_a = w_ld;
      default: ;
    endcase
    DONE  = (r_state == SHOW);
    STATE = r_state;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
    end else begin
      if (w_ld_a) r_a <= DATA_IN;
      if (w_ld_b) r_b <= DATA_IN;
      if (w_exec) begin
        r_result <= SUB_RESULT;
        r_ovf    <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (SUB_RESULT[WIDTH-1] != r_a[WIDTH-1]);
        r_zero   <= (SUB_RESULT == '0);
        r_neg    <= SUB_RESULT[WIDTH-1];
      end
    end
  end

  assign A      = r_a;
  assign B      = r_b;
  assign RESULT = r_result;
  assign OVF    = r_ovf;
  assign ZERO   = r_zero;
  assign NEG    = r_neg;

endmodule
